// File: rtl/belfft_twiddle_agu.sv
// ============================================================================
// Module  : belfft_twiddle_agu
// Purpose : Twiddle ROM address generator and coefficient output stage for the
//           radix-2 bel_fft butterfly. Optional BELFFT_TW_CONJ_EN conjugates
//           the coefficient for inverse transforms.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module belfft_twiddle_agu #(
  parameter int WORD_WIDTH = 16,
  parameter int MAX_AWIDTH = 6
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [3:0]              lg_size_i,
  input  logic                    inv_i,
  input  logic                    adv_i,
  output logic [MAX_AWIDTH-1:0]   adr_o,
  output logic                    rd_o,
  input  logic [2*WORD_WIDTH-1:0] tw_i,
  output logic [2*WORD_WIDTH-1:0] tw_o,
  output logic                    tw_vld_o,
  output logic [3:0]              stage_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_RUN   = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;

  localparam logic [3:0]            c_LG_MAX = 4'(MAX_AWIDTH + 1);
  localparam logic [MAX_AWIDTH-1:0] c_ONES   = {MAX_AWIDTH{1'b1}};
  localparam logic [WORD_WIDTH-1:0] c_MIN    = {1'b1, {(WORD_WIDTH-1){1'b0}}};
  localparam logic [WORD_WIDTH-1:0] c_MAX    = {1'b0, {(WORD_WIDTH-1){1'b1}}};

  logic [1:0]              r_state;
  logic [1:0]              w_next;
  logic [3:0]              r_lg;
  logic [3:0]              r_stage;
  logic [MAX_AWIDTH-1:0]   r_bfly;
  logic [MAX_AWIDTH-1:0]   r_adr;
  logic [3:0]              r_stage_q;
  logic                    r_rd;
  logic                    r_v2;
  logic                    r_vld;
  logic [2*WORD_WIDTH-1:0] r_tw;
  logic                    r_done;
  logic                    r_err;

  logic                    w_lg_ok;
  logic                    w_start_ok;
  logic                    w_start_bad;
  logic                    w_req;
  logic                    w_drain_hit;
  logic [MAX_AWIDTH-1:0]   w_mask;
  logic [MAX_AWIDTH-1:0]   w_half_m1;
  logic [3:0]              w_shamt;
  logic [MAX_AWIDTH-1:0]   w_adr;
  logic                    w_bfly_wrap;
  logic                    w_last;
  logic [WORD_WIDTH-1:0]   w_imag;
  logic [WORD_WIDTH-1:0]   w_imag_neg;
  logic [2*WORD_WIDTH-1:0] w_tw_proc;

  assign w_lg_ok = (lg_size_i >= 4'd1) && (lg_size_i <= c_LG_MAX);

  // Mask keeps the low 'stage' bits of bfly; shift scales to the N/2 ROM span.
  assign w_mask      = ~(c_ONES << r_stage);
  assign w_half_m1   = ~(c_ONES << (r_lg - 4'd1));
  assign w_shamt     = r_lg - 4'd1 - r_stage;
  assign w_adr       = (r_bfly & w_mask) << w_shamt;
  assign w_bfly_wrap = (r_bfly == w_half_m1);
  assign w_last      = w_req && w_bfly_wrap && (r_stage == (r_lg - 4'd1));

  assign w_imag     = tw_i[WORD_WIDTH-1:0];
  assign w_imag_neg = (w_imag == c_MIN) ? c_MAX : -w_imag;

`ifdef BELFFT_TW_CONJ_EN
  logic r_inv;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_inv <= 1'b0;
    end else if (w_start_ok) begin
      r_inv <= inv_i;
    end
  end

  assign w_tw_proc = r_inv ? {tw_i[2*WORD_WIDTH-1:WORD_WIDTH], w_imag_neg} : tw_i;
`else
  logic w_unused_conj;

  assign w_unused_conj = inv_i ^ (^w_imag_neg);
  assign w_tw_proc     = tw_i;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:  if (w_start_ok) w_next = c_RUN;
      c_RUN:   if (w_last) w_next = c_DRAIN;
      c_DRAIN: if (r_done) w_next = c_IDLE;
      default: w_next = c_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    w_start_ok  = 1'b0;
    w_start_bad = 1'b0;
    w_req       = 1'b0;
    w_drain_hit = 1'b0;
    busy_o      = 1'b0;
    case (r_state)
      c_IDLE: begin
        w_start_ok  = start_i && w_lg_ok;
        w_start_bad = start_i && !w_lg_ok;
      end
      c_RUN: begin
        busy_o = 1'b1;
        w_req  = adv_i;
      end
      c_DRAIN: begin
        busy_o = 1'b1;
        // Only the final valid has an empty pipeline behind it.
        w_drain_hit = r_vld && !r_v2 && !r_rd && !r_done;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_lg    <= 4'd0;
      r_stage <= 4'd0;
      r_bfly  <= '0;
    end else if (w_start_ok) begin
      r_lg    <= lg_size_i;
      r_stage <= 4'd0;
      r_bfly  <= '0;
    end else if (w_req) begin
      if (w_bfly_wrap) begin
        r_bfly  <= '0;
        r_stage <= r_stage + 4'd1;
      end else begin
        r_bfly <= r_bfly + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd      <= 1'b0;
      r_adr     <= '0;
      r_stage_q <= 4'd0;
      r_v2      <= 1'b0;
      r_vld     <= 1'b0;
      r_tw      <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_rd   <= w_req;
      r_v2   <= r_rd;
      r_vld  <= r_v2;
      r_done <= w_drain_hit;
      r_err  <= w_start_bad;
      if (w_req) begin
        r_adr     <= w_adr;
        r_stage_q <= r_stage;
      end
      if (r_v2) begin
        r_tw <= w_tw_proc;
      end
    end
  end

  assign adr_o    = r_adr;
  assign rd_o     = r_rd;
  assign stage_o  = r_stage_q;
  assign tw_o     = r_tw;
  assign tw_vld_o = r_vld;
  assign done_o   = r_done;
  assign err_o    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_belfft_twiddle_agu.sv
// ============================================================================
// Module  : tb_belfft_twiddle_agu
// Purpose : Directed self-checking bench for belfft_twiddle_agu with a
//           one-cycle-latency twiddle ROM model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_belfft_twiddle_agu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  lg = 4'd0;
  logic        inv = 1'b0;
  logic        adv = 1'b0;
  logic [5:0]  adr_o;
  logic        rd_o;
  logic [31:0] tw_i = 32'd0;
  logic [31:0] tw_o;
  logic        tw_vld_o;
  logic [3:0]  stage_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] rom [0:63];

  belfft_twiddle_agu #(.WORD_WIDTH(16), .MAX_AWIDTH(6)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .lg_size_i(lg), .inv_i(inv),
    .adv_i(adv), .adr_o(adr_o), .rd_o(rd_o), .tw_i(tw_i), .tw_o(tw_o),
    .tw_vld_o(tw_vld_o), .stage_o(stage_o), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_o) tw_i <= rom[adr_o];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_tf(input logic [3:0] l, input logic iv);
    lg = l; inv = iv; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    total++;
    if ({rd_o, tw_vld_o, busy_o, done_o, err_o} !== 5'b0 || adr_o !== 6'd0 ||
        stage_o !== 4'd0 || tw_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_state got rd=%b vld=%b busy=%b done=%b err=%b adr=%0d stg=%0d tw=%h want all zero",
               rd_o, tw_vld_o, busy_o, done_o, err_o, adr_o, stage_o, tw_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_n8;
    int exp_adr[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};
    start_tf(4'd3, 1'b0);
    total++;
    if (busy_o !== 1'b1) begin
      bad++; $display("FAIL n8_busy got %b want 1", busy_o);
    end
    adv = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (rd_o !== 1'b1 || adr_o !== 6'(exp_adr[i]) || stage_o !== 4'(i / 4)) begin
        bad++;
        $display("FAIL n8_req%0d got rd=%b adr=%0d stg=%0d want rd=1 adr=%0d stg=%0d",
                 i, rd_o, adr_o, stage_o, exp_adr[i], i / 4);
      end
    end
    adv = 1'b0;
    tick();
    total++;
    if (rd_o !== 1'b0 || done_o !== 1'b0) begin
      bad++; $display("FAIL n8_t2 got rd=%b done=%b want 0 0", rd_o, done_o);
    end
    tick();
    total++;
    if (tw_vld_o !== 1'b1 || tw_o !== 32'h1003_0009 || done_o !== 1'b0) begin
      bad++; $display("FAIL n8_t3 got vld=%b tw=%h done=%b want 1 10030009 0", tw_vld_o, tw_o, done_o);
    end
    tick();
    total++;
    if (done_o !== 1'b1 || tw_vld_o !== 1'b0) begin
      bad++; $display("FAIL n8_done got done=%b vld=%b want 1 0", done_o, tw_vld_o);
    end
    tick();
    total++;
    if (done_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL n8_idle got done=%b busy=%b want 0 0", done_o, busy_o);
    end
  endtask

  task automatic test_lg1;
    int busy_cnt = 0;
    start_tf(4'd1, 1'b0);
    adv = 1'b1;
    for (int k = 0; k < 7; k++) begin
      if (busy_o === 1'b1) busy_cnt++;
      if (k >= 1) begin
        total++;
        if (rd_o !== (k == 1) || done_o !== (k == 4) || (k == 1 && adr_o !== 6'd0)) begin
          bad++;
          $display("FAIL lg1_cycle%0d got rd=%b done=%b adr=%0d want rd=%b done=%b adr=0",
                   k, rd_o, done_o, adr_o, k == 1, k == 4);
        end
      end
      tick();
    end
    adv = 1'b0;
    total++;
    if (busy_cnt != 5) begin
      bad++; $display("FAIL lg1_busy_len got %0d want 5", busy_cnt);
    end
  endtask

  task automatic test_err;
    logic [3:0] bad_lg[2] = '{4'd0, 4'd8};
    for (int i = 0; i < 2; i++) begin
      adv = 1'b1;
      start_tf(bad_lg[i], 1'b0);
      total++;
      if (err_o !== 1'b1 || busy_o !== 1'b0 || rd_o !== 1'b0) begin
        bad++;
        $display("FAIL err_lg%0d got err=%b busy=%b rd=%b want 1 0 0", bad_lg[i], err_o, busy_o, rd_o);
      end
      tick();
      total++;
      if (err_o !== 1'b0 || busy_o !== 1'b0 || rd_o !== 1'b0) begin
        bad++;
        $display("FAIL err_after_lg%0d got err=%b busy=%b rd=%b want 0 0 0", bad_lg[i], err_o, busy_o, rd_o);
      end
      adv = 1'b0;
    end
  endtask

  task automatic test_conj;
    logic [31:0] vin[4] = '{32'h7FFF_8000, 32'h5A82_A57E, 32'h7FFF_8000, 32'h5A82_A57E};
    logic        vinv[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
`ifdef BELFFT_TW_CONJ_EN
    logic [31:0] vexp[4] = '{32'h7FFF_7FFF, 32'h5A82_5A82, 32'h7FFF_8000, 32'h5A82_A57E};
`else
    logic [31:0] vexp[4] = '{32'h7FFF_8000, 32'h5A82_A57E, 32'h7FFF_8000, 32'h5A82_A57E};
`endif
    logic [31:0] saved;
    saved = rom[0];
    for (int i = 0; i < 4; i++) begin
      rom[0] = vin[i];
      start_tf(4'd1, vinv[i]);
      adv = 1'b1;
      tick();
      adv = 1'b0;
      tick(); tick();
      total++;
      if (tw_vld_o !== 1'b1 || tw_o !== vexp[i]) begin
        bad++;
        $display("FAIL conj%0d inv=%b got vld=%b tw=%h want 1 %h", i, vinv[i], tw_vld_o, tw_o, vexp[i]);
      end
      tick(); tick();
    end
    rom[0] = saved;
  endtask

  task automatic test_gapped;
    int   pat[5] = '{1, 0, 0, 1, 1};
    int   exp_adr[32];
    int   issued = 0, rd_idx = 0, vld_idx = 0, last_i = -1;
    int   s, b;
    logic [2:0] hist = 3'b000;
    bit   seen_done = 1'b0;
    for (int r = 0; r < 32; r++) begin
      s = r / 8; b = r % 8;
      exp_adr[r] = (b & ((1 << s) - 1)) << (3 - s);
    end
    start_tf(4'd4, 1'b0);
    for (int i = 0; i < 200 && !seen_done; i++) begin
      adv = (issued < 32) && (pat[i % 5] != 0);
      if (adv) begin
        issued++;
        if (issued == 32) last_i = i;
      end
      tick();
      hist = {hist[1:0], adv};
      total++;
      if (rd_o !== hist[0] || tw_vld_o !== hist[2] ||
          done_o !== (last_i >= 0 && i == last_i + 3)) begin
        bad++;
        $display("FAIL gap_ctrl%0d got rd=%b vld=%b done=%b want rd=%b vld=%b done=%b",
                 i, rd_o, tw_vld_o, done_o, hist[0], hist[2], last_i >= 0 && i == last_i + 3);
      end
      if (rd_o === 1'b1 && rd_idx < 32) begin
        total++;
        if (adr_o !== 6'(exp_adr[rd_idx])) begin
          bad++; $display("FAIL gap_adr%0d got %0d want %0d", rd_idx, adr_o, exp_adr[rd_idx]);
        end
        rd_idx++;
      end
      if (tw_vld_o === 1'b1 && vld_idx < 32) begin
        total++;
        if (tw_o !== rom[exp_adr[vld_idx]]) begin
          bad++; $display("FAIL gap_tw%0d got %h want %h", vld_idx, tw_o, rom[exp_adr[vld_idx]]);
        end
        vld_idx++;
      end
      if (done_o === 1'b1) seen_done = 1'b1;
    end
    adv = 1'b0;
    total++;
    if (!seen_done || rd_idx != 32 || vld_idx != 32) begin
      bad++; $display("FAIL gap_complete got done=%b rd=%0d vld=%0d want 1 32 32", seen_done, rd_idx, vld_idx);
    end
    tick();
  endtask

  task automatic test_mid_reset;
    start_tf(4'd6, 1'b0);
    adv = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    adv = 1'b0;
    total++;
    if (busy_o !== 1'b0 || tw_vld_o !== 1'b0 || rd_o !== 1'b0) begin
      bad++; $display("FAIL rst_flush got busy=%b vld=%b rd=%b want 0 0 0", busy_o, tw_vld_o, rd_o);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (done_o !== 1'b0 || tw_vld_o !== 1'b0 || busy_o !== 1'b0) begin
        bad++; $display("FAIL rst_quiet%0d got done=%b vld=%b busy=%b want 0 0 0", i, done_o, tw_vld_o, busy_o);
      end
    end
    start_tf(4'd6, 1'b0);
    adv = 1'b1;
    tick();
    tick();
    adv = 1'b0;
    total++;
    if (rd_o !== 1'b1 || adr_o !== 6'd0 || stage_o !== 4'd0) begin
      bad++; $display("FAIL rst_restart got rd=%b adr=%0d stg=%0d want 1 0 0", rd_o, adr_o, stage_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    for (int a = 0; a < 64; a++) rom[a] = {16'h1000 + 16'(a), 16'(a * 3)};
    test_reset();
    test_n8();
    test_lg1();
    test_err();
    test_conj();
    test_gapped();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
